// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state and transaction owner encodings.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_I = 3'd1,
    ISSUE_D = 3'd2,
    WAIT_I  = 3'd3,
    WAIT_D  = 3'd4
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  // Counter width able to hold the value 'limit' itself.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SAT   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] SatVal = WIDTH'(SAT);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != SatVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one stalling memory port between instruction fetch and data access,
// one transaction at a time, with an IF starvation guard and a transaction watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 16,
  parameter int unsigned STARVE = 4,
  parameter int unsigned WDOG   = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_busy,
  input  logic          mem_done,
  output logic          err
);

  localparam int unsigned SW = cnt_width(STARVE);
  localparam int unsigned WW = cnt_width(WDOG);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE);
  localparam logic [WW-1:0] WdogLast  = WW'(WDOG - 1);

  arb_state_e    state_q;
  arb_owner_e    owner_q;
  logic          mem_rd_q;
  logic          mem_wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          err_q;
  logic          err_d;

  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wdog_cnt;

  logic dm_req;
  logic in_idle;
  logic in_wait;
  logic starve_full;
  logic grant_if;
  logic grant_dm;
  logic done_if_ok;
  logic done_dm_ok;
  logic abort;

  assign dm_req      = dm_rd | dm_wr;
  assign in_idle     = (state_q == IDLE);
  assign in_wait     = (state_q == WAIT_I) || (state_q == WAIT_D);
  assign starve_full = (starve_cnt == StarveMax);

  assign grant_if = in_idle && if_req && (!dm_req || starve_full);
  assign grant_dm = in_idle && dm_req && !grant_if;

  assign done_if_ok = (state_q == WAIT_I) && mem_done;
  assign done_dm_ok = (state_q == WAIT_D) && mem_done;

  // Watchdog fires on the WDOG-th busy cycle; a real completion that same cycle wins.
  assign abort = !in_idle && (wdog_cnt == WdogLast) && !(done_if_ok || done_dm_ok);

  arb_sat_counter #(
    .WIDTH (SW),
    .SAT   (STARVE)
  ) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (grant_dm && if_req),
    .clr_i (grant_if || !if_req),
    .cnt_o (starve_cnt)
  );

  arb_sat_counter #(
    .WIDTH (WW),
    .SAT   (WDOG)
  ) u_wdog_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (!in_idle),
    .clr_i (in_idle),
    .cnt_o (wdog_cnt)
  );

  assign err_d = err_q
               | (mem_done && !in_wait)
               | (dm_rd && dm_wr)
               | abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_d;
      unique case (state_q)
        IDLE: begin
          if (grant_if) begin
            state_q  <= ISSUE_I;
            owner_q  <= OWN_IF;
            mem_rd_q <= 1'b1;
            mem_wr_q <= 1'b0;
            addr_q   <= if_addr;
          end else if (grant_dm) begin
            state_q  <= ISSUE_D;
            owner_q  <= OWN_DM;
            mem_rd_q <= !dm_wr;
            mem_wr_q <= dm_wr;
            addr_q   <= dm_addr;
            wdata_q  <= dm_wdata;
          end
        end
        ISSUE_I, ISSUE_D: begin
          if (abort) begin
            state_q  <= IDLE;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
          end else if (!mem_busy) begin
            state_q  <= (state_q == ISSUE_I) ? WAIT_I : WAIT_D;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
          end
        end
        WAIT_I, WAIT_D: begin
          if (mem_done || abort) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;

  // Completion is combinational so the requester sees done in the mem_done cycle.
  assign if_done  = done_if_ok || (abort && (owner_q == OWN_IF));
  assign dm_done  = done_dm_ok || (abort && (owner_q == OWN_DM));
  assign if_rdata = done_if_ok ? mem_rdata : '0;
  assign dm_rdata = done_dm_ok ? mem_rdata : '0;
  assign if_stall = if_req && !if_done;
  assign dm_stall = dm_req && !dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_rd, dm_wr, mem_busy, mem_done;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, if_stall, dm_done, dm_stall, mem_rd, mem_wr, err;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW     (16),
    .DW     (16),
    .STARVE (4),
    .WDOG   (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .if_stall  (if_stall),
    .dm_rd     (dm_rd),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .dm_stall  (dm_stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .mem_busy  (mem_busy),
    .mem_done  (mem_done),
    .err       (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ir, dr, dw;
    logic [15:0] ia, da, wd;
    logic        busy, done;
    logic [15:0] rdat;
    logic        e_rd, e_wr;
    logic [15:0] e_addr, e_wd;
    logic        e_ifd, e_dmd;
    logic [15:0] e_rdat;
    logic        e_err;
  } vec_t;

  function automatic vec_t v(
    input logic ir, dr, dw, input logic [15:0] ia, da, wd,
    input logic busy, done, input logic [15:0] rdat,
    input logic e_rd, e_wr, input logic [15:0] e_addr, e_wd,
    input logic e_ifd, e_dmd, input logic [15:0] e_rdat, input logic e_err);
    vec_t r;
    r.ir = ir; r.dr = dr; r.dw = dw; r.ia = ia; r.da = da; r.wd = wd;
    r.busy = busy; r.done = done; r.rdat = rdat;
    r.e_rd = e_rd; r.e_wr = e_wr; r.e_addr = e_addr; r.e_wd = e_wd;
    r.e_ifd = e_ifd; r.e_dmd = e_dmd; r.e_rdat = e_rdat; r.e_err = e_err;
    return r;
  endfunction

  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // IF read served by a responder that completes one cycle after the strobe.
  task automatic if_read(input string tag, input logic [15:0] a, input logic [15:0] d);
    int unsigned c;
    logic saw, got;
    if_req = 1'b1; if_addr = a; mem_rdata = d; saw = 1'b0; got = 1'b0; c = 0;
    while (!got && c < 10) begin
      c++;
      mem_done = saw;
      @(negedge clk);
      if (if_done) begin
        got = 1'b1;
        chk($sformatf("%s if_rdata", tag), 32'(if_rdata), 32'(d));
        chk($sformatf("%s latency", tag), c, 3);
      end
      saw = mem_rd;
      step();
    end
    if_req = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    chk($sformatf("%s if_done seen", tag), 32'(got), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int grants[10];
    int ng, busy_at, rd_cycles;
    logic saw, got;

    rst = 1'b1;
    if_req = 0; dm_rd = 0; dm_wr = 0; mem_busy = 0; mem_done = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;

    //           ir dr dw ia       da       wd       bsy dn rdat     rd wr addr     wd       ifd dmd erd      err
    // single IF read, done two cycles after strobe
    tbl.push_back(v(1, 0, 0, 16'h0100, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(v(1, 0, 0, 16'h0100, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(v(1, 0, 0, 16'h0100, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(v(1, 0, 0, 16'h0100, 16'h0000, 16'h0000, 0, 1, 16'hBEEF, 0, 0, 16'h0100, 16'h0000, 1, 0, 16'hBEEF, 0));
    tbl.push_back(v(0, 0, 0, 16'h0100, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 0));
    // simultaneous IF read and DM write: DM first
    tbl.push_back(v(1, 0, 1, 16'h0200, 16'h0010, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h0100, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(v(1, 0, 1, 16'h0200, 16'h0010, 16'h1234, 0, 0, 16'h0000, 0, 1, 16'h0010, 16'h1234, 0, 0, 16'h0000, 0));
    tbl.push_back(v(1, 0, 1, 16'h0200, 16'h0010, 16'h1234, 0, 1, 16'h0000, 0, 0, 16'h0010, 16'h0000, 0, 1, 16'h0000, 0));
    tbl.push_back(v(1, 0, 0, 16'h0200, 16'h0010, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(v(1, 0, 0, 16'h0200, 16'h0010, 16'h1234, 0, 0, 16'h0000, 1, 0, 16'h0200, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(v(1, 0, 0, 16'h0200, 16'h0010, 16'h1234, 0, 1, 16'h5A5A, 0, 0, 16'h0200, 16'h0000, 1, 0, 16'h5A5A, 0));
    tbl.push_back(v(0, 0, 0, 16'h0200, 16'h0010, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h0200, 16'h0000, 0, 0, 16'h0000, 0));
    // DM read with mem_busy for three ISSUE cycles; dm_addr wiggles while held
    tbl.push_back(v(0, 1, 0, 16'h0000, 16'h0030, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0200, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(v(0, 1, 0, 16'h0000, 16'h0031, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(v(0, 1, 0, 16'h0000, 16'h0032, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(v(0, 1, 0, 16'h0000, 16'h0033, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(v(0, 1, 0, 16'h0000, 16'h0034, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(v(0, 1, 0, 16'h0000, 16'h0034, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 0));
    tbl.push_back(v(0, 1, 0, 16'h0000, 16'h0034, 16'h0000, 0, 1, 16'h0C0C, 0, 0, 16'h0030, 16'h0000, 0, 1, 16'h0C0C, 0));
    tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0034, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 0));

    // reset state
    @(negedge clk);
    chk("reset mem_rd", 32'(mem_rd), 0);
    chk("reset mem_wr", 32'(mem_wr), 0);
    chk("reset mem_addr", 32'(mem_addr), 0);
    chk("reset mem_wdata", 32'(mem_wdata), 0);
    chk("reset if_done", 32'(if_done), 0);
    chk("reset dm_done", 32'(dm_done), 0);
    chk("reset err", 32'(err), 0);
    rst = 1'b0;
    step();

    foreach (tbl[i]) begin
      if_req = tbl[i].ir; dm_rd = tbl[i].dr; dm_wr = tbl[i].dw;
      if_addr = tbl[i].ia; dm_addr = tbl[i].da; dm_wdata = tbl[i].wd;
      mem_busy = tbl[i].busy; mem_done = tbl[i].done; mem_rdata = tbl[i].rdat;
      @(negedge clk);
      chk($sformatf("row%0d mem_rd", i), 32'(mem_rd), 32'(tbl[i].e_rd));
      chk($sformatf("row%0d mem_wr", i), 32'(mem_wr), 32'(tbl[i].e_wr));
      chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("row%0d if_done", i), 32'(if_done), 32'(tbl[i].e_ifd));
      chk($sformatf("row%0d dm_done", i), 32'(dm_done), 32'(tbl[i].e_dmd));
      chk($sformatf("row%0d if_stall", i), 32'(if_stall), 32'(tbl[i].ir & ~tbl[i].e_ifd));
      chk($sformatf("row%0d dm_stall", i), 32'(dm_stall), 32'((tbl[i].dr | tbl[i].dw) & ~tbl[i].e_dmd));
      chk($sformatf("row%0d err", i), 32'(err), 32'(tbl[i].e_err));
      if (tbl[i].e_wr) chk($sformatf("row%0d mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].e_wd));
      if (tbl[i].e_ifd) chk($sformatf("row%0d if_rdata", i), 32'(if_rdata), 32'(tbl[i].e_rdat));
      if (tbl[i].e_dmd) chk($sformatf("row%0d dm_rdata", i), 32'(dm_rdata), 32'(tbl[i].e_rdat));
      step();
    end
    mem_done = 0; mem_busy = 0; mem_rdata = '0;

    // starvation: DM read held with IF held -> DDDDI DDDDI (1 = IF grant)
    if_req = 1; if_addr = 16'h0A00; dm_rd = 1; dm_addr = 16'h0D00;
    saw = 0; ng = 0;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      mem_done = saw;
      @(negedge clk);
      if (mem_rd) begin
        grants[ng] = (mem_addr == 16'h0A00) ? 1 : (mem_addr == 16'h0D00) ? 0 : 2;
        ng++;
      end
      saw = mem_rd;
      step();
    end
    chk("starve grant count", ng, 10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("starve grant%0d owner", k), grants[k], (k == 4 || k == 9) ? 1 : 0);
    dm_rd = 0; mem_done = 1;
    @(negedge clk);
    chk("starve drain if_done", 32'(if_done), 1);
    step();
    if_req = 0; mem_done = 0;
    step();

    // mem_done outside WAIT is ignored but sticks err
    @(negedge clk);
    chk("stray done err before", 32'(err), 0);
    step();
    mem_done = 1;
    @(negedge clk);
    chk("stray done no if_done", 32'(if_done), 0);
    chk("stray done no dm_done", 32'(dm_done), 0);
    step();
    mem_done = 0;
    @(negedge clk);
    chk("stray done err set", 32'(err), 1);
    step();
    @(negedge clk);
    chk("stray done err sticky", 32'(err), 1);
    step();

    // async reset in WAIT while mem_done is high
    dm_rd = 1; dm_addr = 16'h0040;
    step();
    step();
    mem_done = 1; mem_rdata = 16'h1111;
    #1;
    chk("rst-wait dm_done before", 32'(dm_done), 1);
    rst = 1;
    #1;
    chk("rst-wait dm_done", 32'(dm_done), 0);
    chk("rst-wait mem_rd", 32'(mem_rd), 0);
    chk("rst-wait mem_addr", 32'(mem_addr), 0);
    chk("rst-wait err", 32'(err), 0);
    mem_done = 0; dm_rd = 0; mem_rdata = '0;
    @(negedge clk);
    rst = 0;
    step();
    if_read("post-rst", 16'h0070, 16'h2468);

    // dm_rd and dm_wr together: error, performed as a write
    dm_rd = 1; dm_wr = 1; dm_addr = 16'h0050; dm_wdata = 16'h7777;
    @(negedge clk);
    chk("rdwr err before grant", 32'(err), 0);
    step();
    @(negedge clk);
    chk("rdwr mem_wr", 32'(mem_wr), 1);
    chk("rdwr mem_rd", 32'(mem_rd), 0);
    chk("rdwr mem_addr", 32'(mem_addr), 32'h0050);
    chk("rdwr mem_wdata", 32'(mem_wdata), 32'h7777);
    chk("rdwr err", 32'(err), 1);
    step();
    mem_done = 1;
    @(negedge clk);
    chk("rdwr dm_done", 32'(dm_done), 1);
    step();
    dm_rd = 0; dm_wr = 0; mem_done = 0;

    rst = 1;
    @(negedge clk);
    chk("rst clears err", 32'(err), 0);
    rst = 0;
    step();

    // watchdog: memory never completes
    dm_rd = 1; dm_addr = 16'h0060; mem_rdata = 16'hFFFF;
    step();
    got = 0; busy_at = 0; rd_cycles = 0;
    for (int n = 1; n <= 80 && !got; n++) begin
      @(negedge clk);
      if (mem_rd) rd_cycles++;
      if (dm_done) begin
        got = 1;
        busy_at = n;
        chk("wdog dm_rdata", 32'(dm_rdata), 0);
      end
      step();
    end
    dm_rd = 0; mem_rdata = '0;
    chk("wdog done seen", 32'(got), 1);
    chk("wdog done cycle", busy_at, 64);
    chk("wdog strobe cycles", rd_cycles, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("wdog err sticky%0d", k), 32'(err), 1);
      chk($sformatf("wdog idle mem_rd%0d", k), 32'(mem_rd), 0);
      step();
    end
    if_read("post-wdog", 16'h0080, 16'h3579);
    @(negedge clk);
    chk("post-wdog err", 32'(err), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
